// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: command field layout, mode and FSM encodings.
// Combinational helpers only; no latency, no backpressure.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_PWM    = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam int unsigned PAT_LSB  = 0;
    localparam int unsigned PAT_W    = 8;
    localparam int unsigned DUTY_LSB = 8;
    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned PER_LSB  = 16;
    localparam int unsigned PER_W    = 8;
    localparam int unsigned MODE_LSB = 24;
    localparam int unsigned MODE_W   = 2;

    function automatic logic [7:0] led_of(
        input mode_e      mode,
        input logic [7:0] pattern,
        input logic [7:0] duty,
        input logic       phase,
        input logic [7:0] chase,
        input logic [7:0] pwm
    );
        case (mode)
            MODE_STATIC: return pattern;
            MODE_BLINK:  return phase ? pattern : 8'h00;
            MODE_CHASE:  return chase;
            default:     return pattern & {8{pwm < duty}};
        endcase
    endfunction

endpackage

// File: rtl/tick_gen_m.sv
// Prescaler: o_tick is high for one clock every PRESCALE clocks; i_clr restarts the count.
// o_tick decodes the registered count (no input-to-output path); never stalls.
module tick_gen_m #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic i_clk0,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = (i_clr || o_tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge i_clk0) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_seq_m.sv
// LED sequencer (static/blink/chase/PWM); o_led shows a new command 2 clocks after accept.
// Ready drops for the single LOAD cycle after each accept; valid during LOAD waits.
module led_seq_m
    import led_seq_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic        i_clk0,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    input  logic [31:0] i_cmd,
    output logic        o_cmd_ready,
    output logic [7:0]  o_led,
    output logic [31:0] o_status
);

    state_e      state_q;
    logic [31:0] cmd_q;
    logic [7:0]  step_q, step_d;
    logic [7:0]  chase_q, chase_d;
    logic [7:0]  pwm_q, pwm_d;
    logic [7:0]  led_q, led_d;
    logic        phase_q, phase_d;

    logic        load;
    logic        accept;
    logic        tick;
    logic        step;
    logic [7:0]  pattern, duty, period, step_last;
    mode_e       mode;

    assign load        = (state_q == ST_LOAD);
    assign o_cmd_ready = (state_q == ST_RUN);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign o_led       = led_q;
    assign o_status    = cmd_q;

    tick_gen_m #(.PRESCALE(PRESCALE)) u_tick (
        .i_clk0 (i_clk0),
        .i_rst  (i_rst),
        .i_clr  (load),
        .o_tick (tick)
    );

    always_comb begin
        pattern   = cmd_q[PAT_LSB  +: PAT_W];
        duty      = cmd_q[DUTY_LSB +: DUTY_W];
        period    = cmd_q[PER_LSB  +: PER_W];
        mode      = mode_e'(cmd_q[MODE_LSB +: MODE_W]);
        step_last = (period == 8'd0) ? 8'd0 : period - 8'd1;
        step      = tick && (step_q == step_last);

        // LOAD restarts every timer from the freshly captured command; a step landing here is dropped.
        if (load) begin
            step_d  = 8'd0;
            phase_d = 1'b1;
            chase_d = pattern;
            pwm_d   = 8'd0;
        end else begin
            step_d  = tick ? (step ? 8'd0 : step_q + 8'd1) : step_q;
            phase_d = phase_q ^ step;
            chase_d = step ? {chase_q[6:0], chase_q[7]} : chase_q;
            pwm_d   = pwm_q + 8'd1;
        end

        // Built from cmd_q, never i_cmd, so the LED drive is fully registered.
        led_d = led_of(mode, pattern, duty, phase_d, chase_d, pwm_d);
    end

    always_ff @(posedge i_clk0) begin
        if (i_rst) begin
            state_q <= ST_LOAD;
            cmd_q   <= '0;
            step_q  <= '0;
            phase_q <= 1'b0;
            chase_q <= '0;
            pwm_q   <= '0;
            led_q   <= '0;
        end else begin
            if (state_q == ST_RUN) begin
                if (accept) begin
                    cmd_q   <= i_cmd;
                    state_q <= ST_LOAD;
                end
            end else begin
                state_q <= ST_RUN;
            end
            step_q  <= step_d;
            phase_q <= phase_d;
            chase_q <= chase_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: tb/tb_led_seq_m.sv
// Bench for led_seq_m at PRESCALE=4: vector table, directed corner sequences, and a
// randomized run against a cycle-count reference model of the LED behaviour.
module tb_led_seq_m;

    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [31:0] cmd;
    logic        rdy;
    logic [7:0]  led;
    logic [31:0] status;

    always #5 clk = ~clk;

    led_seq_m #(.PRESCALE(PS)) dut (
        .i_clk0      (clk),
        .i_rst       (rst),
        .i_cmd_valid (vld),
        .i_cmd       (cmd),
        .o_cmd_ready (rdy),
        .o_led       (led),
        .o_status    (status)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: active command and the number of clocks since it was loaded.
    bit          m_load;
    logic [31:0] m_status;
    logic [31:0] m_act;
    int          m_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] cmd;
        logic        rdy;
        logic [7:0]  led;
        logic [31:0] st;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] exp_led(input logic [31:0] c, input int t);
        logic [7:0] pat;
        int duty, pm, k;
        pat  = c[7:0];
        duty = int'(c[15:8]);
        pm   = (c[23:16] == 8'd0) ? 1 : int'(c[23:16]);
        k    = t / (PS * pm);
        case (c[25:24])
            2'd0:    return pat;
            2'd1:    return ((k % 2) == 0) ? pat : 8'h00;
            2'd2:    return rotl(pat, k % 8);
            default: return ((t % 256) < duty) ? pat : 8'h00;
        endcase
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_load = 1'b1; m_status = '0; m_act = '0; m_t = 0;
        end else if (m_load) begin
            m_load = 1'b0; m_act = m_status; m_t = 0;
        end else begin
            m_t++;
            if (vld) begin
                m_status = cmd;
                m_load   = 1'b1;
            end
        end
        #1;
        chk32("model_led", 32'(led), 32'(exp_led(m_act, m_t)));
        chk32("model_rdy", 32'(rdy), 32'(!m_load));
        chk32("model_status", status, m_status);
    endtask

    task automatic send(input logic [31:0] c);
        int n;
        n = 0;
        while (!rdy && n < 16) begin
            cycle();
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_wait: ready=%b required 1", rdy);
        end
        vld = 1'b1;
        cmd = c;
        cycle();
        vld = 1'b0;
        chk32("send_accept_rdy", 32'(rdy), 32'(0));
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, ones, others;
        logic [7:0]  chase_exp[4];
        logic [31:0] c;

        rst = 1'b1; vld = 1'b0; cmd = '0;
        m_load = 1'b1; m_status = '0; m_act = '0; m_t = 0;

        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 8'h00, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,         1'b0, 8'h00, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_00A5, 1'b0, 8'h00, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 8'h00, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_00A5, 1'b0, 8'h00, 32'h0000_00A5};
        tbl[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 8'hA5, 32'h0000_00A5};
        tbl[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 8'hA5, 32'h0000_00A5};

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst;
            vld = tbl[i].vld;
            cmd = tbl[i].cmd;
            cycle();
            chk32($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(tbl[i].rdy));
            chk32($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].led));
            chk32($sformatf("vec%0d_status", i), status, tbl[i].st);
        end

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (led !== 8'hA5) bad++;
        end
        chk32("static_hold_bad_cycles", 32'(bad), 32'(0));

        send(32'h0102_000F);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) cycle();
            if (led !== ((((i / 8) % 2) == 0) ? 8'h0F : 8'h00)) bad++;
        end
        chk32("blink_bad_cycles", 32'(bad), 32'(0));

        chase_exp[0] = 8'h81; chase_exp[1] = 8'h03; chase_exp[2] = 8'h06; chase_exp[3] = 8'h0C;
        send(32'h0201_0081);
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) cycle();
            if ((i % 4) == 0) chk32($sformatf("chase_step%0d", i / 4), 32'(led), 32'(chase_exp[i / 4]));
        end
        send(32'h0201_0080);
        chk32("chase80_first", 32'(led), 32'h80);
        repeat (4) cycle();
        chk32("chase80_wrap", 32'(led), 32'h01);

        send(32'h0300_40FF);
        ones = 0; others = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) cycle();
            if (led === 8'hFF) ones++;
            else if (led !== 8'h00) others++;
        end
        chk32("pwm40_on_cycles", 32'(ones), 32'(64));
        chk32("pwm40_other_values", 32'(others), 32'(0));

        send(32'h0300_00FF);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) cycle();
            if (led !== 8'h00) bad++;
        end
        chk32("pwm00_nonzero_cycles", 32'(bad), 32'(0));

        send(32'h0300_FFFF);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) cycle();
            if (led === 8'hFF) ones++;
        end
        chk32("pwmFF_on_cycles", 32'(ones), 32'(255));

        vld = 1'b1; cmd = 32'h0000_0011;
        cycle();
        chk32("held_accept1_status", status, 32'h0000_0011);
        chk32("held_accept1_rdy", 32'(rdy), 32'(0));
        cmd = 32'h0000_0022;
        cycle();
        chk32("held_load_rdy", 32'(rdy), 32'(1));
        chk32("held_load_status", status, 32'h0000_0011);
        chk32("held_load_led", 32'(led), 32'h11);
        cycle();
        chk32("held_accept2_status", status, 32'h0000_0022);
        chk32("held_accept2_rdy", 32'(rdy), 32'(0));
        vld = 1'b0;
        cycle();
        chk32("held_second_led", 32'(led), 32'h22);

        send(32'h0200_0001);
        repeat (6) cycle();
        chk32("restart_before", 32'(led), 32'h02);
        send(32'h0200_0001);
        chk32("restart_after", 32'(led), 32'h01);

        send(32'h0102_00FF);
        repeat (5) cycle();
        chk32("rst_blink_before", 32'(led), 32'hFF);
        vld = 1'b1; cmd = 32'h0000_0055; rst = 1'b1;
        cycle();
        chk32("rst_blink_led", 32'(led), 32'h00);
        chk32("rst_blink_rdy", 32'(rdy), 32'(0));
        chk32("rst_blink_status", status, 32'h0);
        rst = 1'b0; vld = 1'b0;
        cycle();
        chk32("rst_recover_rdy", 32'(rdy), 32'(1));

        for (int i = 0; i < 3000; i++) begin
            rst = (($urandom % 400) == 0);
            vld = (($urandom % 40) == 0);
            c = $urandom;
            c[23:16] = 8'($urandom % 4);
            cmd = c;
            cycle();
        end
        rst = 1'b0; vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
